wptr_sync_full: RTL and testbench

WPTR_SYNC_FULL -- requirements
Module: wptr_sync_full

---
 rtl/fifo_pkg.sv | 43 ++++
 rtl/sync_gray_chain.sv | 29 ++
 rtl/wptr_sync_full.sv | 112 +++++++++++
 tb/tb_wptr_sync_full.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for asynchronous FIFO pointer logic: Gray conversion, popcount and
// parameter legality checks, sized for the widest supported pointer.
package fifo_pkg;

    localparam int unsigned PTR_MAX_W = 13;

    typedef logic [PTR_MAX_W-1:0] ptr_max_t;

    function automatic ptr_max_t bin2gray(input ptr_max_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_max_t gray2bin(input ptr_max_t g);
        ptr_max_t b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic int unsigned popcount(input ptr_max_t v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < PTR_MAX_W; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

    function automatic bit addrsize_ok(input int unsigned a);
        return (a >= 2) && (a <= 12);
    endfunction

    function automatic bit sync_stages_ok(input int unsigned s);
        return (s >= 2) && (s <= 4);
    endfunction

    function automatic bit af_level_ok(input int unsigned af, input int unsigned a);
        return (af >= 1) && (af <= (32'd1 << a));
    endfunction

endpackage

// File: rtl/sync_gray_chain.sv
// Multi-flop synchronizer for a Gray-coded pointer entering the clk domain.
module sync_gray_chain #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/wptr_sync_full.sv
// Write-side pointer, full/level tracking and sticky error flags for an asynchronous FIFO.
// Occupancy uses the synchronized read pointer, so full is pessimistic, never optimistic.
module wptr_sync_full
    import fifo_pkg::*;
#(
    parameter int unsigned ADDRSIZE    = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AF_LEVEL    = (32'd1 << ADDRSIZE) - 32'd2
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   rptr,
    input  logic                wclr_err,
    output logic [ADDRSIZE:0]   wptr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wq_rptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf,
    output logic                wgray_err
);

    localparam int unsigned       PW         = ADDRSIZE + 1;
    localparam logic [ADDRSIZE:0] AF_THR     = AF_LEVEL[ADDRSIZE:0];
    localparam logic [2:0]        PRIME_DONE = SYNC_STAGES[2:0];

    if (!addrsize_ok(ADDRSIZE)) begin : g_bad_addrsize
        $error("ADDRSIZE must be in 2..12");
    end
    if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync_stages
        $error("SYNC_STAGES must be in 2..4");
    end
    if (!af_level_ok(AF_LEVEL, ADDRSIZE)) begin : g_bad_af_level
        $error("AF_LEVEL must be in 1..2**ADDRSIZE");
    end

    logic [ADDRSIZE:0] sync_pre;
    logic [ADDRSIZE:0] wq_rptr_q;
    logic [ADDRSIZE:0] wbin_q, wbin_d;
    logic [ADDRSIZE:0] wptr_q, wptr_d;
    logic [ADDRSIZE:0] wlevel_q;
    logic [ADDRSIZE:0] rbin, occ;
    logic              wfull_q, wfull_d;
    logic              waf_q, waf_d;
    logic              wovf_q, wovf_d;
    logic              werr_q, werr_d;
    logic              accept, gray_hop;
    logic [2:0]        prime_q, prime_d;

    // Final stage is kept local so the value about to land in wq_rptr can be hop-checked.
    sync_gray_chain #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES - 1)
    ) u_rptr_sync (
        .clk   (wclk),
        .rst_n (wrst_n),
        .d     (rptr),
        .q     (sync_pre)
    );

    always_comb begin
        accept   = winc & ~wfull_q;
        wbin_d   = wbin_q + {{ADDRSIZE{1'b0}}, accept};
        wptr_d   = PW'(bin2gray(ptr_max_t'(wbin_d)));
        rbin     = PW'(gray2bin(ptr_max_t'(wq_rptr_q)));
        occ      = wbin_d - rbin;
        wfull_d  = wptr_d == {~wq_rptr_q[ADDRSIZE:ADDRSIZE-1], wq_rptr_q[ADDRSIZE-2:0]};
        waf_d    = occ >= AF_THR;
        wovf_d   = (winc & wfull_q) | (wovf_q & ~wclr_err);
        prime_d  = (prime_q == PRIME_DONE) ? prime_q : prime_q + 3'd1;
        // Reset zeros in the chain are not real samples; only judge hops between real ones.
        gray_hop = (prime_q == PRIME_DONE) &&
                   (popcount(ptr_max_t'(sync_pre ^ wq_rptr_q)) > 1);
        werr_d   = gray_hop | (werr_q & ~wclr_err);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wq_rptr_q <= '0;
            wbin_q    <= '0;
            wptr_q    <= '0;
            wlevel_q  <= '0;
            wfull_q   <= 1'b0;
            waf_q     <= 1'b0;
            wovf_q    <= 1'b0;
            werr_q    <= 1'b0;
            prime_q   <= '0;
        end else begin
            wq_rptr_q <= sync_pre;
            wbin_q    <= wbin_d;
            wptr_q    <= wptr_d;
            wlevel_q  <= occ;
            wfull_q   <= wfull_d;
            waf_q     <= waf_d;
            wovf_q    <= wovf_d;
            werr_q    <= werr_d;
            prime_q   <= prime_d;
        end
    end

    assign wptr         = wptr_q;
    assign waddr        = wbin_q[ADDRSIZE-1:0];
    assign wq_rptr      = wq_rptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = waf_q;
    assign wlevel       = wlevel_q;
    assign wovf         = wovf_q;
    assign wgray_err    = werr_q;

endmodule

// File: tb/tb_wptr_sync_full.sv
// Bench for wptr_sync_full: two instances (2 and 3 sync stages) against a timeline model.
`timescale 1ns/1ps
module tb_wptr_sync_full;

    localparam int NS = 8192;

    logic       wclk = 1'b0;
    logic       wrst_n = 1'b1;
    logic       winc = 1'b0;
    logic       wclr_err = 1'b0;
    logic [4:0] rptr = 5'd0;

    logic [4:0] wptr_o [2];
    logic [3:0] waddr_o [2];
    logic [4:0] wq_o [2];
    logic [4:0] wlevel_o [2];
    logic       wfull_o [2];
    logic       waf_o [2];
    logic       wovf_o [2];
    logic       wgerr_o [2];

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 wclk = ~wclk;

    wptr_sync_full #(.ADDRSIZE(4), .SYNC_STAGES(2), .AF_LEVEL(14)) u_dut_s2 (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .rptr(rptr), .wclr_err(wclr_err),
        .wptr(wptr_o[0]), .waddr(waddr_o[0]), .wq_rptr(wq_o[0]), .wfull(wfull_o[0]),
        .walmost_full(waf_o[0]), .wlevel(wlevel_o[0]), .wovf(wovf_o[0]),
        .wgray_err(wgerr_o[0])
    );

    wptr_sync_full #(.ADDRSIZE(4), .SYNC_STAGES(3), .AF_LEVEL(14)) u_dut_s3 (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .rptr(rptr), .wclr_err(wclr_err),
        .wptr(wptr_o[1]), .waddr(waddr_o[1]), .wq_rptr(wq_o[1]), .wfull(wfull_o[1]),
        .walmost_full(waf_o[1]), .wlevel(wlevel_o[1]), .wovf(wovf_o[1]),
        .wgray_err(wgerr_o[1])
    );

    function automatic int g2b(input logic [4:0] g);
        for (int i = 0; i < 32; i++) begin
            if (5'(i ^ (i >> 1)) == g) return i;
        end
        return 0;
    endfunction

    function automatic logic [4:0] b2g(input int b);
        return 5'(b ^ (b >> 1));
    endfunction

    task automatic chk(input string name, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, k, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string name);
        for (int k = 0; k < 2; k++) begin
            chk({name, "_wptr"}, k, int'(wptr_o[k]), 0);
            chk({name, "_waddr"}, k, int'(waddr_o[k]), 0);
            chk({name, "_wq_rptr"}, k, int'(wq_o[k]), 0);
            chk({name, "_wfull"}, k, int'(wfull_o[k]), 0);
            chk({name, "_walmost_full"}, k, int'(waf_o[k]), 0);
            chk({name, "_wlevel"}, k, int'(wlevel_o[k]), 0);
            chk({name, "_wovf"}, k, int'(wovf_o[k]), 0);
            chk({name, "_wgray_err"}, k, int'(wgerr_o[k]), 0);
        end
    endtask

    // Model: samp[k][n] is the rptr sampled at the n-th edge since reset; the synchronized
    // pointer after edge n is the sample taken lat-1 edges earlier (0 before that).
    int         m_bin [2];
    int         m_level [2];
    int         m_n [2];
    bit         m_full [2];
    bit         m_af [2];
    bit         m_ovf [2];
    bit         m_gerr [2];
    logic [4:0] m_wq [2];
    logic [4:0] samp [2][NS];

    always @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_bin[k] <= 0;
                m_level[k] <= 0;
                m_n[k] <= 0;
                m_full[k] <= 1'b0;
                m_af[k] <= 1'b0;
                m_ovf[k] <= 1'b0;
                m_gerr[k] <= 1'b0;
                m_wq[k] <= 5'd0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int lat, nn, wb, occ;
                logic [4:0] wq_b, wq_a;
                bit acc, hop;
                lat = (k == 0) ? 2 : 3;
                nn = m_n[k] + 1;
                wq_b = (nn - 1 >= lat) ? samp[k][nn - lat] : 5'd0;
                wq_a = (nn >= lat) ? samp[k][nn - lat + 1] : 5'd0;
                acc = winc && !m_full[k];
                wb = (m_bin[k] + int'(acc)) % 32;
                occ = (wb - g2b(wq_b) + 32) % 32;
                hop = (nn - 1 >= lat) && ($countones(wq_a ^ wq_b) > 1);
                samp[k][nn] <= rptr;
                m_n[k] <= nn;
                m_bin[k] <= wb;
                m_level[k] <= occ;
                m_full[k] <= (occ == 16);
                m_af[k] <= (occ >= 14);
                m_ovf[k] <= (winc && m_full[k]) || (m_ovf[k] && !wclr_err);
                m_gerr[k] <= hop || (m_gerr[k] && !wclr_err);
                m_wq[k] <= wq_a;
            end
        end
    end

    always @(negedge wclk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("wptr", k, int'(wptr_o[k]), int'(b2g(m_bin[k])));
                chk("waddr", k, int'(waddr_o[k]), m_bin[k] % 16);
                chk("wq_rptr", k, int'(wq_o[k]), int'(m_wq[k]));
                chk("wfull", k, int'(wfull_o[k]), int'(m_full[k]));
                chk("walmost_full", k, int'(waf_o[k]), int'(m_af[k]));
                chk("wlevel", k, int'(wlevel_o[k]), m_level[k]);
                chk("wovf", k, int'(wovf_o[k]), int'(m_ovf[k]));
                chk("wgray_err", k, int'(wgerr_o[k]), int'(m_gerr[k]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        int d0, d1, rc;
        #1 wrst_n = 1'b0;
        #2 chk_all_zero("reset");
        cmp_en = 1'b1;
        @(negedge wclk) wrst_n = 1'b1;

        // Fill from empty with rptr parked at 0.
        for (int i = 1; i <= 16; i++) begin
            @(negedge wclk) winc = 1'b1;
            @(posedge wclk) #1;
            chk("fill_level", 0, int'(wlevel_o[0]), i);
            chk("fill_af", 0, int'(waf_o[0]), int'(i >= 14));
            chk("fill_full", 0, int'(wfull_o[0]), int'(i == 16));
        end
        chk("full_wptr", 0, int'(wptr_o[0]), int'(5'b11000));

        // Overflow: writes while full are dropped and flagged.
        for (int i = 0; i < 3; i++) begin
            @(posedge wclk) #1;
            chk("ovf_wptr_hold", 0, int'(wptr_o[0]), int'(5'b11000));
            chk("ovf_set", 0, int'(wovf_o[0]), 1);
        end
        @(negedge wclk) begin winc = 1'b0; wclr_err = 1'b1; end
        @(posedge wclk) #1 chk("ovf_clear", 0, int'(wovf_o[0]), 0);
        @(negedge wclk) winc = 1'b1;
        @(posedge wclk) #1 chk("ovf_set_beats_clear", 0, int'(wovf_o[0]), 1);
        @(negedge wclk) winc = 1'b0;
        @(negedge wclk) wclr_err = 1'b0;

        // Read pointer step while full: release latency SYNC_STAGES+1.
        @(negedge wclk) rptr = 5'b00001;
        d0 = 0;
        d1 = 0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge wclk) #1;
            if (d0 == 0 && !wfull_o[0]) d0 = e;
            if (d1 == 0 && !wfull_o[1]) d1 = e;
        end
        chk("full_release_edges_s2", 0, d0, 3);
        chk("full_release_edges_s3", 1, d1, 4);
        chk("level_after_read", 0, int'(wlevel_o[0]), 15);

        // Illegal two-bit Gray jump.
        @(negedge wclk) rptr = 5'b00000;
        repeat (5) @(negedge wclk);
        rptr = 5'b00011;
        d0 = 0;
        for (int e = 1; e <= 6; e++) begin
            @(posedge wclk) #1;
            if (d0 == 0 && wgerr_o[0]) d0 = e;
        end
        chk("gray_err_edges", 0, d0, 2);
        chk("gray_err_sticky", 0, int'(wgerr_o[0]), 1);
        @(negedge wclk) wclr_err = 1'b1;
        @(posedge wclk) #1 chk("gray_err_clear", 0, int'(wgerr_o[0]), 0);
        @(negedge wclk) wclr_err = 1'b0;

        // Walk reads up to 8 so occupancy is 8, then stream through a pointer wrap.
        for (int b = 3; b <= 8; b++) begin
            @(negedge wclk) rptr = b2g(b);
        end
        repeat (4) @(negedge wclk);
        chk("wrap_start_level", 0, int'(wlevel_o[0]), 8);
        for (int c = 1; c <= 42; c++) begin
            @(negedge wclk);
            rptr = b2g((8 + c) % 32);
            winc = (c >= 3);
            @(posedge wclk) #1;
            chk("wrap_level", 0, int'(wlevel_o[0]), 8);
            chk("wrap_full", 0, int'(wfull_o[0]), 0);
            chk("wrap_gray_err", 0, int'(wgerr_o[0]), 0);
        end
        @(negedge wclk) winc = 1'b0;
        repeat (4) @(negedge wclk);
        chk("wrap_wptr", 0, int'(wptr_o[0]), int'(b2g(24)));

        // Reset in the middle of a burst at occupancy 10.
        for (int i = 0; i < 4; i++) begin
            @(negedge wclk) winc = 1'b1;
        end
        @(posedge wclk) #1 chk("pre_reset_level", 0, int'(wlevel_o[0]), 10);
        #1 wrst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        @(negedge wclk) begin winc = 1'b0; rptr = 5'b10110; end
        @(negedge wclk) wrst_n = 1'b1;
        repeat (6) @(negedge wclk);
        chk("post_reset_gray_err_s2", 0, int'(wgerr_o[0]), 0);
        chk("post_reset_gray_err_s3", 1, int'(wgerr_o[1]), 0);
        chk("post_reset_wq_rptr", 0, int'(wq_o[0]), int'(5'b10110));

        // Randomized traffic with a legal reader, rare glitches, clears and resets.
        #2 begin wrst_n = 1'b0; rptr = 5'd0; end
        @(negedge wclk) wrst_n = 1'b1;
        rc = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge wclk);
            winc = ($urandom_range(0, 99) < 60);
            wclr_err = ($urandom_range(0, 99) < 4);
            if (rc != m_bin[0] && $urandom_range(0, 99) < 50) rc = (rc + 1) % 32;
            rptr = b2g(rc);
            if ($urandom_range(0, 299) == 0) rptr = rptr ^ 5'b00110;
            if ($urandom_range(0, 599) == 0) begin
                #2 begin wrst_n = 1'b0; rptr = 5'd0; rc = 0; end
                @(negedge wclk) wrst_n = 1'b1;
            end
        end
        @(negedge wclk) begin winc = 1'b0; wclr_err = 1'b0; end
        repeat (2) @(negedge wclk);
        cmp_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
